// File: rtl/alu_seq_if.sv
// Handshake bundle between operand fetch (producer), alu_seq, and writeback (consumer).
interface alu_seq_if #(
    parameter int unsigned WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       opcode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic [2:0]       flags;

    modport master (
        output in_valid, opcode, a, b, out_ready,
        input  in_ready, out_valid, result, flags
    );

    modport slave (
        input  in_valid, opcode, a, b, out_ready,
        output in_ready, out_valid, result, flags
    );
endinterface

// File: rtl/alu_seq.sv
// Handshaked multi-cycle ALU: saturating arithmetic, byte reduction, nibble SIMD add,
// a 1-bit-per-cycle shifter, and a persistent {Z,V,N} flag register.
module alu_seq #(
    parameter int unsigned WIDTH = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    alu_seq_if.slave   io_bus
);
    localparam int unsigned SHW   = $clog2(WIDTH);
    localparam int unsigned LANES = WIDTH / 8;
    localparam int unsigned NIBS  = WIDTH / 4;

    localparam logic [2:0] OpAdd = 3'b000, OpSub = 3'b001, OpXor = 3'b010, OpRed = 3'b011,
                           OpSll = 3'b100, OpSra = 3'b101, OpRor = 3'b110, OpPad = 3'b111;

    localparam logic [WIDTH-1:0] SatMax = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SatMin = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    state_e           r_state;
    logic [WIDTH-1:0] r_work;
    logic [SHW-1:0]   r_cnt;
    logic [2:0]       r_op;
    logic [WIDTH-1:0] r_result;
    logic [2:0]       r_flags;

    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_diff;
    logic [WIDTH-1:0] w_red;
    logic [WIDTH-1:0] w_pad;
    logic [4:0]       w_lane;
    logic [WIDTH-1:0] w_load_res;
    logic             w_load_sat;
    logic [WIDTH-1:0] w_shifted;
    logic [SHW-1:0]   w_shamt;
    logic             w_is_shift;

    function automatic logic [2:0] upd_flags(input logic [2:0] op, input logic [WIDTH-1:0] res,
                                             input logic sat, input logic [2:0] old);
        case (op)
            OpAdd, OpSub:        return {(res == '0), sat, res[WIDTH-1]};
            OpXor, OpSll,
            OpSra, OpRor:        return {(res == '0), old[1:0]};
            default:             return old;
        endcase
    endfunction

    assign w_sum      = {io_bus.a[WIDTH-1], io_bus.a} + {io_bus.b[WIDTH-1], io_bus.b};
    assign w_diff     = {io_bus.a[WIDTH-1], io_bus.a} - {io_bus.b[WIDTH-1], io_bus.b};
    assign w_shamt    = io_bus.b[SHW-1:0];
    assign w_is_shift = io_bus.opcode[2] && (io_bus.opcode != OpPad);

    // Modular WIDTH-bit accumulation yields the low bits of the full-precision sum.
    always_comb begin
        w_red = '0;
        for (int i = 0; i < int'(LANES); i++) begin
            w_red = w_red + WIDTH'($signed(io_bus.a[8*i +: 8]))
                          + WIDTH'($signed(io_bus.b[8*i +: 8]));
        end
    end

    always_comb begin
        w_pad  = '0;
        w_lane = '0;
        for (int i = 0; i < int'(NIBS); i++) begin
            w_lane = {io_bus.a[4*i+3], io_bus.a[4*i +: 4]} + {io_bus.b[4*i+3], io_bus.b[4*i +: 4]};
            if (w_lane[4] != w_lane[3]) begin
                w_pad[4*i +: 4] = w_lane[4] ? 4'b1000 : 4'b0111;
            end else begin
                w_pad[4*i +: 4] = w_lane[3:0];
            end
        end
    end

    always_comb begin
        w_load_res = io_bus.a;
        w_load_sat = 1'b0;
        case (io_bus.opcode)
            OpAdd: begin
                w_load_sat = w_sum[WIDTH] ^ w_sum[WIDTH-1];
                w_load_res = w_load_sat ? (w_sum[WIDTH] ? SatMin : SatMax) : w_sum[WIDTH-1:0];
            end
            OpSub: begin
                w_load_sat = w_diff[WIDTH] ^ w_diff[WIDTH-1];
                w_load_res = w_load_sat ? (w_diff[WIDTH] ? SatMin : SatMax) : w_diff[WIDTH-1:0];
            end
            OpXor:   w_load_res = io_bus.a ^ io_bus.b;
            OpRed:   w_load_res = w_red;
            OpPad:   w_load_res = w_pad;
            default: w_load_res = io_bus.a;
        endcase
    end

    always_comb begin
        w_shifted = r_work;
        case (r_op)
            OpSll:   w_shifted = {r_work[WIDTH-2:0], 1'b0};
            OpSra:   w_shifted = {r_work[WIDTH-1], r_work[WIDTH-1:1]};
            OpRor:   w_shifted = {r_work[0], r_work[WIDTH-1:1]};
            default: w_shifted = r_work;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= StIdle;
            r_work   <= '0;
            r_cnt    <= '0;
            r_op     <= OpAdd;
            r_result <= '0;
            r_flags  <= 3'b000;
        end else begin
            case (r_state)
                StIdle: begin
                    if (io_bus.in_valid) begin
                        r_op <= io_bus.opcode;
                        if (w_is_shift && (w_shamt != '0)) begin
                            r_work  <= io_bus.a;
                            r_cnt   <= w_shamt;
                            r_state <= StShift;
                        end else begin
                            r_result <= w_load_res;
                            r_flags  <= upd_flags(io_bus.opcode, w_load_res, w_load_sat, r_flags);
                            r_state  <= StDone;
                        end
                    end
                end
                StShift: begin
                    r_work <= w_shifted;
                    r_cnt  <= r_cnt - 1'b1;
                    if (r_cnt == SHW'(1)) begin
                        r_result <= w_shifted;
                        r_flags  <= upd_flags(r_op, w_shifted, 1'b0, r_flags);
                        r_state  <= StDone;
                    end
                end
                StDone: begin
                    if (io_bus.out_ready) begin
                        r_state <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign io_bus.in_ready  = (r_state == StIdle);
    assign io_bus.out_valid = (r_state == StDone);
    assign io_bus.result    = r_result;
    assign io_bus.flags     = r_flags;
endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq: hand-computed vectors, latency and handshake checks.
module tb_alu_seq;
    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    alu_seq_if #(.WIDTH(16)) bus ();

    alu_seq #(.WIDTH(16)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .io_bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [2:0] op, input logic [15:0] av, input logic [15:0] bv);
        bus.in_valid = 1'b1;
        bus.opcode   = op;
        bus.a        = av;
        bus.b        = bv;
    endtask

    // Complete the handoff from a negedge with out_valid high; ends on the following negedge.
    task automatic handoff(input string tag);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check({tag, "_post_valid"}, 32'(bus.out_valid), 32'd0);
        check({tag, "_post_ready"}, 32'(bus.in_ready), 32'd1);
    endtask

    task automatic do_op(input string tag, input logic [2:0] op, input logic [15:0] av,
                         input logic [15:0] bv, input logic [15:0] exp_res,
                         input logic [2:0] exp_flags, input int exp_lat);
        int   n;
        logic ready_hi;
        check({tag, "_ready_in"}, 32'(bus.in_ready), 32'd1);
        drive(op, av, bv);
        @(posedge clk);
        #1;
        // Scramble inputs so an op in flight must rely on its latched copy.
        drive(3'b010, 16'hA5A5, 16'h0003);
        bus.in_valid = 1'b0;
        n = 1;
        ready_hi = 1'b0;
        @(negedge clk);
        while (!bus.out_valid && n < 40) begin
            if (bus.in_ready) ready_hi = 1'b1;
            @(negedge clk);
            n++;
        end
        if (bus.in_ready) ready_hi = 1'b1;
        check({tag, "_latency"}, 32'(n), 32'(exp_lat));
        check({tag, "_result"}, 32'(bus.result), 32'(exp_res));
        check({tag, "_flags"}, 32'(bus.flags), 32'(exp_flags));
        check({tag, "_busy"}, 32'(ready_hi), 32'd0);
        handoff(tag);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        bus.in_valid  = 1'b0;
        bus.opcode    = 3'b000;
        bus.a         = '0;
        bus.b         = '0;
        bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_ready", 32'(bus.in_ready), 32'd1);
        check("rst_valid", 32'(bus.out_valid), 32'd0);
        check("rst_result", 32'(bus.result), 32'd0);
        check("rst_flags", 32'(bus.flags), 32'd0);

        do_op("add_sat", 3'b000, 16'h7FFF, 16'h0001, 16'h7FFF, 3'b010, 1);
        do_op("sub_zero", 3'b001, 16'h0005, 16'h0005, 16'h0000, 3'b100, 1);
        do_op("sub_sat", 3'b001, 16'h8000, 16'h0001, 16'h8000, 3'b011, 1);
        do_op("sra4", 3'b101, 16'h8000, 16'h0004, 16'hF800, 3'b011, 5);
        do_op("paddsb", 3'b111, 16'h7878, 16'h1111, 16'h7979, 3'b011, 1);
        do_op("red_pos", 3'b011, 16'h0102, 16'h0304, 16'h000A, 3'b011, 1);
        do_op("red_neg", 3'b011, 16'h8080, 16'h8080, 16'hFE00, 3'b011, 1);
        do_op("ror0", 3'b110, 16'h1234, 16'h0000, 16'h1234, 3'b011, 1);
        do_op("sra15", 3'b101, 16'h8001, 16'h000F, 16'hFFFF, 3'b011, 16);

        // Backpressure: XOR held in DONE while a second op waits on in_valid.
        check("xor_ready_in", 32'(bus.in_ready), 32'd1);
        drive(3'b010, 16'hFFFF, 16'hFFFF);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("xor_valid", 32'(bus.out_valid), 32'd1);
        check("xor_result", 32'(bus.result), 32'h0000);
        check("xor_flags", 32'(bus.flags), 32'(3'b111));
        drive(3'b000, 16'h0001, 16'h0002);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("bp_valid", 32'(bus.out_valid), 32'd1);
            check("bp_result", 32'(bus.result), 32'h0000);
            check("bp_ready", 32'(bus.in_ready), 32'd0);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check("bp_hand_valid", 32'(bus.out_valid), 32'd0);
        check("bp_hand_ready", 32'(bus.in_ready), 32'd1);
        check("bp_hand_result", 32'(bus.result), 32'h0000);
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("add2_valid", 32'(bus.out_valid), 32'd1);
        check("add2_result", 32'(bus.result), 32'h0003);
        check("add2_flags", 32'(bus.flags), 32'(3'b000));
        handoff("add2");

        do_op("ror1", 3'b110, 16'h0001, 16'h0001, 16'h8000, 3'b000, 2);

        // Reset in the middle of a long shift aborts it.
        drive(3'b100, 16'h0001, 16'h000F);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("sll_busy", 32'(bus.in_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        check("abort_valid", 32'(bus.out_valid), 32'd0);
        check("abort_flags", 32'(bus.flags), 32'd0);
        check("abort_result", 32'(bus.result), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("abort_ready", 32'(bus.in_ready), 32'd1);
        check("abort_no_result", 32'(bus.out_valid), 32'd0);
        check("abort_result_hold", 32'(bus.result), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
